reg_file_dumper: RTL

//  Debug/observability reader for the RV32I register file. On i_start, walks
//  x0..x(DEPTH-1) through one asynchronous register-file read port and streams

---
 rtl/reg_file_dumper.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/reg_file_dumper.sv
// ---------------------------------------------------------------------------
// reg_file_dumper
//
// Debug/observability reader for the RV32I register file. A pulse on
// i_start walks the registers from x0 (or x1 when SKIP_X0 is set) up to
// x(DEPTH-1). It reads each one through a spare asynchronous read port and
// streams it out on a valid/ready interface, tagged with its index.
//
// Each word costs two cycles: a READ cycle that presents the address and
// captures the combinational read data, then a SEND cycle that holds the
// word until the consumer accepts it.
//
// Ports
//   i_clk     clock
//   i_arst_n  asynchronous active-low reset
//   i_start   start a dump (only looked at while idle)
//   i_abort   abandon the dump and return to idle (no o_done pulse)
//   o_raddr   register-file read address (registered, equals the walk index)
//   i_rdata   register-file read data for o_raddr
//   o_valid   o_data/o_idx/o_last are valid
//   i_ready   consumer accepts the word when o_valid & i_ready
//   o_data    captured register value
//   o_idx     register index of o_data
//   o_last    set with the word for index DEPTH-1
//   o_busy    a dump is in progress (READ/SEND/DONE)
//   o_done    one-cycle pulse after the last word has been accepted
// ---------------------------------------------------------------------------
module reg_file_dumper #(
    parameter int N       = 32,
    parameter int DEPTH   = 32,
    parameter int SKIP_X0 = 0,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_start,
    input  logic          i_abort,
    output logic [AW-1:0] o_raddr,
    input  logic [N-1:0]  i_rdata,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [N-1:0]  o_data,
    output logic [AW-1:0] o_idx,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [AW-1:0] FIRST_IDX = (SKIP_X0 != 0) ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] idx_reg,   idx_next;
    logic [N-1:0]  data_reg,  data_next;
    logic [AW-1:0] oidx_reg,  oidx_next;
    logic          last_reg,  last_next;

    logic handshake;
    assign handshake = (state_reg == S_SEND) && i_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        oidx_next  = oidx_reg;
        last_next  = last_reg;

        case (state_reg)
            S_IDLE: begin
                // Abort has priority over a simultaneous start.
                if (i_start && !i_abort) begin
                    idx_next   = FIRST_IDX;
                    state_next = S_READ;
                end
            end

            S_READ: begin
                if (i_abort) begin
                    state_next = S_IDLE;
                end else begin
                    data_next  = i_rdata;
                    oidx_next  = idx_reg;
                    last_next  = (idx_reg == LAST_IDX);
                    state_next = S_SEND;
                end
            end

            S_SEND: begin
                if (i_abort) begin
                    // Dropping valid mid-word is intentional on abort.
                    last_next  = 1'b0;
                    state_next = S_IDLE;
                end else if (handshake) begin
                    // o_last is only meaningful alongside o_valid, so it is
                    // cleared as soon as the word leaves.
                    last_next = 1'b0;
                    if (last_reg) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + AW'(1);
                        state_next = S_READ;
                    end
                end
            end

            default: begin
                // S_DONE lasts exactly one cycle; an abort here lands in
                // the same place.
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            data_reg  <= '0;
            oidx_reg  <= '0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            oidx_reg  <= oidx_next;
            last_reg  <= last_next;
        end
    end

    // The read address comes straight from the walk-index register, so there
    // is no combinational path from any input to o_raddr.
    assign o_raddr = idx_reg;
    assign o_data  = data_reg;
    assign o_idx   = oidx_reg;
    assign o_last  = last_reg;
    assign o_valid = (state_reg == S_SEND);
    assign o_busy  = (state_reg != S_IDLE);
    assign o_done  = (state_reg == S_DONE);

endmodule
